instr_prefetch_buffer: RTL and testbench
========================================

# instr_prefetch_buffer

- Fetch stage directly upstream of the multi-cycle processor core.
- Reads sequential 16-bit words from a synchronous instruction ROM and queues them in a small FIFO.
- Presents the head word on `DIN` with `Run` as a valid flag; the core pops one word per `Advance` strobe (instruction word, and the immediate word for mvi).
- A `Redirect` strobe flushes the queue and restarts fetching at a new address (jumps / writes to R7).

## Interface
- `DEPTH`, 4 — FIFO entries; power of two, 2..16.
- `AW`, 8 — ROM address width; fetch PC wraps modulo 2^AW.
- `Clock`  in  1 — single clock, rising edge.
- `Resetn`  in  1 — reset is asynchronous and active-low.
- `Advance`  in  1 — core consumed current `DIN` word; pop.
- `Redirect`  in  1 — flush and restart fetch.
- `RedirectAddr`  in  AW — new fetch address, sampled with `Redirect`.
- `rom_data`  in  16 — ROM read data, valid the cycle after `rom_rd`.
- `rom_rd`  out  1 — ROM read request.
- `rom_addr`  out  AW — ROM read address.
- `DIN`  out  16 — FIFO head word; 0 when empty.
- `Run`  out  1 — FIFO non-empty (`DIN` valid).
- `PC`  out  AW — ROM address of the head word.

## Operation
- State: `fetch_pc` (AW), FIFO data+address arrays, rd/wr pointers, `count` (0..DEPTH), `inflight` (1 bit), `epoch` (1 bit).
- Issue rule: `rom_rd` = `(count + inflight < DEPTH) & ~Redirect`; `rom_addr` = `fetch_pc`.
  - Both are combinational from registered state and `Redirect`.
  - On issue, `fetch_pc` += 1 (wraps 2^AW−1 → 0); `inflight` <= 1, tagged with current `epoch`.
- Return: cycle after issue, `rom_data` is pushed with its address, if its epoch tag equals current `epoch`; otherwise discarded.
- Pop: `Advance & Run` pops the head. `Advance` while `Run`=0 is ignored (no underflow, no state change).
- Push and pop in the same cycle: `count` unchanged; both happen.
- Redirect (priority over all else in its cycle):
  - `count` <= 0, pointers <= 0, `fetch_pc` <= `RedirectAddr`, `epoch` toggles (the in-flight return is dropped).
  - Any `Advance` that cycle is ignored.
  - `Run`=0 from the next cycle until the first new word lands.
- Overflow is impossible by the issue rule; the bench asserts `count` ≤ DEPTH.
- Reset (async, any time, including mid-fetch):
  - `fetch_pc`=0, `count`=0, `inflight`=0, `epoch`=0, pointers=0.
  - Outputs: `Run`=0, `DIN`=0, `PC`=0, `rom_rd`=0 while `Resetn`=0.

## Timing
- Cycle N: `rom_rd`=1, `rom_addr`=A.
- Cycle N+1: `rom_data` valid; captured at the closing edge.
- Cycle N+2: word visible on `DIN`/`Run`.
- Fetch-to-`Run` latency is 2 cycles. First `rom_rd` occurs in the first cycle after `Resetn` deasserts.
- Redirect asserted in cycle R:
  - fetch of `RedirectAddr` issues in R+1;
  - `Run`=1 in R+3.
- Steady state: one issue per cycle while space exists; sustains one pop per cycle once the FIFO is primed.
- `DIN`, `Run`, `PC` are registered-state outputs (no combinational path from `Advance`).

## Configuration
- `FETCH_BYPASS_EN` defined:
  - when the FIFO is empty and a valid (current-epoch) return arrives, `rom_data` drives `DIN`, its address drives `PC`, and `Run`=1 combinationally in cycle N+1.
  - `Advance` in that cycle consumes it; the word is not pushed.
  - Fetch-to-`Run` latency becomes 1; redirect-to-`Run` becomes R+2.
- Undefined: no bypass; all timing as above.

## Test plan
- Reset then idle, ROM[i]=0x1000+i, DEPTH=4, no `Advance`:
  - `rom_rd` high for 4 cycles (addr 0..3), then low;
  - `Run`=1 from cycle 2; `DIN`=0x1000, `PC`=0.
- Continuous `Advance` after priming:
  - `DIN` steps 0x1000, 0x1001, … one per cycle; `Run` never drops.
- `Advance` while empty (cycles 0–1 after reset): ignored; first valid `DIN`=0x1000, `PC`=0.
- `Redirect`=1 with `RedirectAddr`=0x40 and `Advance`=1 in the same cycle, while a fetch is in flight:
  - stale word not delivered;
  - `Run`=0 for 2 cycles, then `DIN`=ROM[0x40], `PC`=0x40.
- Wrap: `Redirect` to 0xFE (AW=8); pops yield PC 0xFE, 0xFF, 0x00, 0x01.
- `Resetn` pulsed low mid-stream: outputs 0 immediately (async); restart from addr 0 with 2-cycle latency; with `FETCH_BYPASS_EN`, 1-cycle latency.

Source files
------------

// File: rtl/instr_prefetch_buffer.sv
// Fetch stage: streams sequential ROM words into a small FIFO feeding the core.
// Optional FETCH_BYPASS_EN forwards a returning word straight to DIN when empty.
module instr_prefetch_buffer #(
    parameter int DEPTH = 4,
    parameter int AW    = 8
) (
    input  logic          Clock,
    input  logic          Resetn,
    input  logic          Advance,
    input  logic          Redirect,
    input  logic [AW-1:0] RedirectAddr,
    input  logic [15:0]   rom_data,
    output logic          rom_rd,
    output logic [AW-1:0] rom_addr,
    output logic [15:0]   DIN,
    output logic          Run,
    output logic [AW-1:0] PC
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [AW-1:0] fetch_pc_q, fetch_pc_d;
    logic [AW-1:0] ret_addr_q;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          inflight_q;
    logic          epoch_q;
    logic          tag_q;

    logic [15:0]   data_q [DEPTH];
    logic [AW-1:0] addr_q [DEPTH];

    logic [CW:0]   occ;
    logic          issue;
    logic          ret_ok;
    logic          empty;
    logic          push;
    logic          pop;
    logic          byp_take;

    always_comb begin
        occ      = {1'b0, count_q} + (CW+1)'(inflight_q);
        issue    = Resetn & ~Redirect & (occ < (CW+1)'(DEPTH));
        rom_rd   = issue;
        rom_addr = fetch_pc_q;
        ret_ok   = inflight_q & (tag_q == epoch_q);
        empty    = (count_q == '0);
        byp_take = 1'b0;
        Run      = ~empty;
        DIN      = empty ? 16'h0 : data_q[rd_ptr_q];
        PC       = empty ? '0 : addr_q[rd_ptr_q];
`ifdef FETCH_BYPASS_EN
        // Empty queue: the returning word is shown directly and may be consumed now.
        if (empty && ret_ok) begin
            Run      = 1'b1;
            DIN      = rom_data;
            PC       = ret_addr_q;
            byp_take = Advance & ~Redirect;
        end
`endif
        pop  = Advance & ~empty & ~Redirect;
        push = ret_ok & ~Redirect & ~byp_take;
    end

    always_comb begin
        fetch_pc_d = fetch_pc_q + AW'(issue);
        rd_ptr_d   = rd_ptr_q + PW'(pop);
        wr_ptr_d   = wr_ptr_q + PW'(push);
        count_d    = count_q + CW'(push) - CW'(pop);
        if (Redirect) begin
            fetch_pc_d = RedirectAddr;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            count_d    = '0;
        end
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            fetch_pc_q <= '0;
            ret_addr_q <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            inflight_q <= 1'b0;
            epoch_q    <= 1'b0;
            tag_q      <= 1'b0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            inflight_q <= issue;
            epoch_q    <= epoch_q ^ Redirect;
            if (issue) begin
                ret_addr_q <= fetch_pc_q;
                tag_q      <= epoch_q;
            end
        end
    end

    always_ff @(posedge Clock) begin
        if (push) begin
            data_q[wr_ptr_q] <= rom_data;
            addr_q[wr_ptr_q] <= ret_addr_q;
        end
    end

endmodule

// File: tb/tb_instr_prefetch_buffer.sv
// Bench for instr_prefetch_buffer: directed vector table, wrap/reset sequences,
// and random traffic against a queue-level reference model.
module tb_instr_prefetch_buffer;

    localparam int DEPTH = 4;
    localparam int AW    = 8;

    logic          Clock = 1'b0;
    logic          Resetn;
    logic          Advance;
    logic          Redirect;
    logic [AW-1:0] RedirectAddr;
    logic [15:0]   rom_data;
    logic          rom_rd;
    logic [AW-1:0] rom_addr;
    logic [15:0]   DIN;
    logic          Run;
    logic [AW-1:0] PC;

    instr_prefetch_buffer #(.DEPTH(DEPTH), .AW(AW)) dut (
        .Clock(Clock), .Resetn(Resetn), .Advance(Advance),
        .Redirect(Redirect), .RedirectAddr(RedirectAddr),
        .rom_data(rom_data), .rom_rd(rom_rd), .rom_addr(rom_addr),
        .DIN(DIN), .Run(Run), .PC(PC)
    );

    always #5 Clock = ~Clock;

    logic [15:0] rom [256];

    always @(posedge Clock)
        rom_data <= rom_rd ? rom[rom_addr] : 16'hBEEF;

    int checks = 0;
    int passes = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s actual=%0h required=%0h @%0t",
                      name, act, exp, $time);
    endtask

    typedef struct packed {
        logic          adv;
        logic          redir;
        logic [AW-1:0] raddr;
        logic          rd;
        logic [AW-1:0] ra;
        logic          run;
        logic [15:0]   din;
        logic [AW-1:0] pc;
    } vec_t;

    vec_t tbl [16];

    typedef struct {
        logic [AW-1:0] a;
        logic [15:0]   d;
    } ent_t;

    ent_t          mq [$];
    bit            pend;
    logic [AW-1:0] paddr;
    logic [AW-1:0] fpc;

    task automatic model_reset();
        mq.delete();
        pend  = 0;
        paddr = '0;
        fpc   = '0;
    endtask

    // Compare this cycle's outputs with the model, then advance it by one edge.
    task automatic model_cycle();
        bit            exp_rd;
        bit            byp;
        bit            exp_run;
        logic [15:0]   exp_din;
        logic [AW-1:0] exp_pc;
        ent_t          e;
        exp_rd = ((mq.size() + int'(pend)) < DEPTH) && !Redirect;
        byp = 0;
`ifdef FETCH_BYPASS_EN
        byp = (mq.size() == 0) && pend;
`endif
        exp_run = (mq.size() > 0) || byp;
        exp_din = 16'h0;
        exp_pc  = '0;
        if (mq.size() > 0) begin
            exp_din = mq[0].d;
            exp_pc  = mq[0].a;
        end else if (byp) begin
            exp_din = rom[paddr];
            exp_pc  = paddr;
        end
        chk("rnd_rom_rd", rom_rd, exp_rd);
        if (exp_rd) chk("rnd_rom_addr", rom_addr, fpc);
        chk("rnd_run", Run, exp_run);
        chk("rnd_din", DIN, exp_din);
        chk("rnd_pc", PC, exp_pc);
        chk("count_le_depth", 32'(dut.count_q <= DEPTH), 1);
        e.a = paddr;
        e.d = rom[paddr];
        if (Redirect) begin
            mq.delete();
            fpc = RedirectAddr;
        end else begin
`ifdef FETCH_BYPASS_EN
            if (pend) mq.push_back(e);
            if (Advance && mq.size() > 0) void'(mq.pop_front());
`else
            if (Advance && mq.size() > 0) void'(mq.pop_front());
            if (pend) mq.push_back(e);
`endif
        end
        pend = exp_rd;
        if (exp_rd) begin
            paddr = fpc;
            fpc   = fpc + 1'b1;
        end
    endtask

    task automatic next_cycle();
        @(posedge Clock);
        #1;
    endtask

    initial begin
        logic [AW-1:0] pcs [4];
        logic [15:0]   dins [4];
        logic [AW-1:0] wpc [4];
        int            npop;
        int            lat;

        for (int i = 0; i < 256; i++) rom[i] = 16'h1000 + 16'(i);
        wpc[0] = 8'hFE; wpc[1] = 8'hFF; wpc[2] = 8'h00; wpc[3] = 8'h01;

        tbl[0]  = '{1, 0, 8'h00, 1, 8'h00, 0, 16'h0000, 8'h00};
        tbl[1]  = '{1, 0, 8'h00, 1, 8'h01, 0, 16'h0000, 8'h00};
        tbl[2]  = '{0, 0, 8'h00, 1, 8'h02, 1, 16'h1000, 8'h00};
        tbl[3]  = '{0, 0, 8'h00, 1, 8'h03, 1, 16'h1000, 8'h00};
        tbl[4]  = '{0, 0, 8'h00, 0, 8'h00, 1, 16'h1000, 8'h00};
        tbl[5]  = '{0, 0, 8'h00, 0, 8'h00, 1, 16'h1000, 8'h00};
        tbl[6]  = '{1, 0, 8'h00, 0, 8'h00, 1, 16'h1000, 8'h00};
        tbl[7]  = '{1, 0, 8'h00, 1, 8'h04, 1, 16'h1001, 8'h01};
        tbl[8]  = '{1, 0, 8'h00, 1, 8'h05, 1, 16'h1002, 8'h02};
        tbl[9]  = '{1, 0, 8'h00, 1, 8'h06, 1, 16'h1003, 8'h03};
        tbl[10] = '{1, 0, 8'h00, 1, 8'h07, 1, 16'h1004, 8'h04};
        tbl[11] = '{1, 0, 8'h00, 1, 8'h08, 1, 16'h1005, 8'h05};
        tbl[12] = '{1, 1, 8'h40, 0, 8'h00, 1, 16'h1006, 8'h06};
        tbl[13] = '{0, 0, 8'h00, 1, 8'h40, 0, 16'h0000, 8'h00};
        tbl[14] = '{0, 0, 8'h00, 1, 8'h41, 0, 16'h0000, 8'h00};
        tbl[15] = '{0, 0, 8'h00, 1, 8'h42, 1, 16'h1040, 8'h40};

        Resetn = 1'b0;
        Advance = 1'b0;
        Redirect = 1'b0;
        RedirectAddr = '0;
        repeat (3) @(posedge Clock);
        #1;
        chk("reset_run", Run, 0);
        chk("reset_din", DIN, 0);
        chk("reset_pc", PC, 0);
        chk("reset_rom_rd", rom_rd, 0);

        Resetn = 1'b1;
`ifndef FETCH_BYPASS_EN
        for (int i = 0; i < 16; i++) begin
            Advance      = tbl[i].adv;
            Redirect     = tbl[i].redir;
            RedirectAddr = tbl[i].raddr;
            @(negedge Clock);
            chk($sformatf("vec%0d_rom_rd", i), rom_rd, tbl[i].rd);
            if (tbl[i].rd) chk($sformatf("vec%0d_rom_addr", i), rom_addr, tbl[i].ra);
            chk($sformatf("vec%0d_run", i), Run, tbl[i].run);
            chk($sformatf("vec%0d_din", i), DIN, tbl[i].din);
            chk($sformatf("vec%0d_pc", i), PC, tbl[i].pc);
            next_cycle();
        end
`endif

        Advance = 1'b0;
        Redirect = 1'b1;
        RedirectAddr = 8'hFE;
        next_cycle();
        Redirect = 1'b0;
        Advance = 1'b1;
        npop = 0;
        for (int c = 0; c < 20 && npop < 4; c++) begin
            @(negedge Clock);
            if (Run) begin
                pcs[npop]  = PC;
                dins[npop] = DIN;
                npop++;
            end
            next_cycle();
        end
        chk("wrap_pop_count", npop, 4);
        for (int i = 0; i < npop; i++) begin
            chk($sformatf("wrap_pc%0d", i), pcs[i], wpc[i]);
            chk($sformatf("wrap_din%0d", i), dins[i], 16'h1000 + 16'(wpc[i]));
        end

        Advance = 1'b0;
        #2;
        Resetn = 1'b0;
        #1;
        chk("async_rst_run", Run, 0);
        chk("async_rst_din", DIN, 0);
        chk("async_rst_pc", PC, 0);
        chk("async_rst_rom_rd", rom_rd, 0);
        next_cycle();
        Resetn = 1'b1;
        lat = -1;
        for (int c = 0; c < 10 && lat < 0; c++) begin
            @(negedge Clock);
            if (Run) begin
                lat = c;
                chk("restart_din", DIN, 16'h1000);
                chk("restart_pc", PC, 0);
            end
            next_cycle();
        end
`ifdef FETCH_BYPASS_EN
        chk("restart_latency", lat, 1);
`else
        chk("restart_latency", lat, 2);
`endif

        Resetn = 1'b0;
        next_cycle();
        Resetn = 1'b1;
        model_reset();
        for (int c = 0; c < 600; c++) begin
            Advance      = ($urandom_range(0, 9) < 6);
            Redirect     = ($urandom_range(0, 15) == 0);
            RedirectAddr = AW'($urandom);
            @(negedge Clock);
            model_cycle();
            next_cycle();
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
